irq_pending_latch: RTL and testbench

Request-capture stage that sits directly upstream of the 16-bit priority encoder.
- Synchronises 16 raw request lines and latches them as sticky pending bits, in edge or level mode.
- Selects the highest-priority unmasked pending bit, bit 15 highest.
- Presents its index with a valid/ready handshake and clears the bit on acceptance.
- Uses the same index encoding, including the 8'hF0 "nothing pending" code, so consumers see a single convention.

---
 rtl/irq_pending_latch.sv | 149 ++++++++++++++
 tb/tb_irq_pending_latch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_latch
//  Purpose  : Synchronises raw interrupt request lines, latches them as sticky
//             pending bits (edge or level capture), and presents the index of
//             the highest-priority unmasked pending bit over a valid/ready
//             handshake. The presented bit is cleared on acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_pending_latch #(
  parameter int                 N         = 16,
  parameter int                 IDX_W     = 8,
  parameter logic [IDX_W-1:0]   NONE_CODE = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             edge_mode,
  input  logic             irq_ready,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_id,
  output logic [N-1:0]     pending,
  output logic             overflow,
  input  logic             clr_ovf
);

  // Every index must fit in IDX_W, and the idle code must never alias one.
  if (N > (2 ** IDX_W) - 1) begin : g_chk_width
    $error("irq_pending_latch: N does not fit in IDX_W");
  end
  if (int'(NONE_CODE) < N) begin : g_chk_none_code
    $error("irq_pending_latch: NONE_CODE collides with a legal index");
  end

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_sync1;
  logic [N-1:0]     r_req_s;
  logic [N-1:0]     r_req_d;
  logic [N-1:0]     r_pending;
  logic             r_overflow;
  logic             r_valid;
  logic [IDX_W-1:0] r_id;

  logic [N-1:0]     w_set;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_elig;
  logic             w_any;
  logic             w_ovf_evt;
  logic [IDX_W-1:0] w_win;

  // Edge mode only reacts to a 0->1 transition of the synchronised line.
  assign w_set     = edge_mode ? (r_req_s & ~r_req_d) : r_req_s;
  // Only a completed handshake clears; the id is always legal while valid.
  assign w_clr     = (r_valid && irq_ready) ? (N'(1) << r_id) : '0;
  assign w_elig    = r_pending & ~mask;
  assign w_any     = |w_elig;
  // A request landing on a bit that is still pending after this cycle's clear.
  assign w_ovf_evt = |(w_set & r_pending & ~w_clr);

  // Priority pick: ascending scan so the highest set index wins.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < N; i++) begin
      if (w_elig[i]) begin
        w_win = IDX_W'(i);
      end
    end
  end

  // Two-flop synchroniser plus one-cycle delay for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_req_s <= '0;
      r_req_d <= '0;
    end else begin
      r_sync1 <= req_in;
      r_req_s <= r_sync1;
      r_req_d <= r_req_s;
    end
  end

  // Sticky pending bits; a new set beats the acceptance clear so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  // Sticky overflow flag; a fresh event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_evt) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // Presentation FSM: latch a winner in IDLE, hold it unchanged until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_id    <= NONE_CODE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_win;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else begin
            r_id    <= NONE_CODE;
            r_valid <= 1'b0;
          end
        end
        S_PRESENT: begin
          if (irq_ready) begin
            r_id    <= NONE_CODE;
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_id    <= NONE_CODE;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign irq_valid = r_valid;
  assign irq_id    = r_id;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_pending_latch
//  Purpose  : Self-checking bench for irq_pending_latch: directed scenarios
//             with literal expectations plus randomized traffic compared each
//             cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_in;
  logic [15:0] mask;
  logic        edge_mode;
  logic        irq_ready;
  logic        irq_valid;
  logic [7:0]  irq_id;
  logic [15:0] pending;
  logic        overflow;
  logic        clr_ovf;

  int checks   = 0;
  int failures = 0;

  irq_pending_latch dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .edge_mode (edge_mode),
    .irq_ready (irq_ready),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] = req_in as sampled k+1 edges ago (after reset: zeros)
  logic [15:0] hist [3];
  logic [15:0] m_pend;
  bit          m_ovf;
  int          m_pres;   // index being presented, -1 when nothing

  function automatic int hibit(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [15:0] rs, rd, setv, clrv, elig;
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = 16'h0;
      m_pend = 16'h0;
      m_ovf  = 1'b0;
      m_pres = -1;
    end else begin
      rs   = hist[1];
      rd   = hist[2];
      setv = edge_mode ? (rs & ~rd) : rs;
      clrv = 16'h0;
      if (m_pres >= 0 && irq_ready) clrv[m_pres] = 1'b1;
      if ((setv & m_pend & ~clrv) != 16'h0) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      elig = m_pend & ~mask;
      if (m_pres >= 0) begin
        if (irq_ready) m_pres = -1;
      end else begin
        m_pres = hibit(elig);
      end
      m_pend  = (m_pend & ~clrv) | setv;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = req_in;
    end
  endtask

  // Model advances on each edge; DUT outputs compared just after it.
  always @(posedge clk) begin
    logic [7:0] exp_id;
    model_step();
    #1;
    exp_id = (m_pres >= 0) ? 8'(m_pres) : 8'hF0;
    chk("model_valid",    32'(irq_valid), 32'(m_pres >= 0));
    chk("model_id",       32'(irq_id),    32'(exp_id));
    chk("model_pending",  32'(pending),   32'(m_pend));
    chk("model_overflow", 32'(overflow),  32'(m_ovf));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic accept();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  initial begin
    int grants;
    rst = 1'b1; req_in = 16'hFFFF; mask = 16'h0; edge_mode = 1'b1;
    irq_ready = 1'b0; clr_ovf = 1'b0;

    // 1: reset dominates, even with every request asserted
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_valid",   32'(irq_valid), 32'h0);
      chk("rst_id",      32'(irq_id), 32'hF0);
      chk("rst_ovf",     32'(overflow), 32'h0);
    end
    rst = 1'b0; req_in = 16'h0;
    repeat (3) tick();

    // 2: edge capture, latency, priority order, clear on accept
    req_in = 16'h0024;
    repeat (3) tick();
    chk("t2_pend_E2",  32'(pending), 32'h0024);
    chk("t2_valid_E2", 32'(irq_valid), 32'h0);
    tick();
    chk("t2_valid_E3", 32'(irq_valid), 32'h1);
    chk("t2_id_E3",    32'(irq_id), 32'd5);
    repeat (2) tick();
    chk("t2_id_hold",  32'(irq_id), 32'd5);
    accept();
    chk("t2_pend_acc", 32'(pending), 32'h0004);
    chk("t2_valid_gap", 32'(irq_valid), 32'h0);
    tick();
    chk("t2_id_next",  32'(irq_id), 32'd2);
    accept();
    chk("t2_pend_empty", 32'(pending), 32'h0);
    chk("t2_id_none",  32'(irq_id), 32'hF0);

    // 3: no preemption by a higher-priority arrival
    req_in = 16'h0; repeat (3) tick();
    req_in = 16'h0008; repeat (4) tick();
    chk("t3_id3", 32'(irq_id), 32'd3);
    req_in = 16'h8008; repeat (5) tick();
    chk("t3_id3_held", 32'(irq_id), 32'd3);
    chk("t3_pend", 32'(pending), 32'h8008);
    accept();
    chk("t3_gap", 32'(irq_valid), 32'h0);
    tick();
    chk("t3_id15", 32'(irq_id), 32'd15);
    accept();

    // 4: masked bit stays pending but is never presented
    req_in = 16'h0; mask = 16'h8000; repeat (3) tick();
    req_in = 16'h8001; repeat (4) tick();
    chk("t4_id0", 32'(irq_id), 32'd0);
    accept();
    chk("t4_pend", 32'(pending), 32'h8000);
    tick();
    chk("t4_masked_idle", 32'(irq_valid), 32'h0);
    mask = 16'h0;
    tick();
    chk("t4_id15", 32'(irq_id), 32'd15);
    accept();

    // 5: re-arrival on the accept edge is kept, not an overflow
    req_in = 16'h0; repeat (3) tick();
    req_in = 16'h0080; repeat (4) tick();
    chk("t5_id7", 32'(irq_id), 32'd7);
    req_in = 16'h0; tick();
    req_in = 16'h0080; tick(); tick();
    accept();
    chk("t5_pend_kept", 32'(pending), 32'h0080);
    chk("t5_no_ovf",    32'(overflow), 32'h0);
    tick();
    chk("t5_id7_again", 32'(irq_id), 32'd7);
    req_in = 16'h0; tick();
    req_in = 16'h0080; repeat (3) tick();
    chk("t5_ovf_set", 32'(overflow), 32'h1);
    repeat (2) tick();
    chk("t5_ovf_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t5_ovf_clr", 32'(overflow), 32'h0);
    accept();
    req_in = 16'h0; repeat (3) tick();

    // 6: level mode with a held line grants every other cycle
    edge_mode = 1'b0; req_in = 16'h0100; irq_ready = 1'b1;
    repeat (4) tick();
    chk("t6_first", 32'(irq_valid), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t6_toggle", 32'(irq_valid), 32'(k % 2));
      if (irq_valid) chk("t6_id8", 32'(irq_id), 32'd8);
    end
    req_in = 16'h0;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (irq_valid) grants++;
      if (k >= 3) chk("t6_stopped", 32'(irq_valid), 32'h0);
    end
    chk("t6_extra_grants_le1", 32'(grants <= 1), 32'h1);
    irq_ready = 1'b0; edge_mode = 1'b1;
    tick();

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req_in = req_in ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) req_in = 16'($urandom);
      if ($urandom_range(0, 19) == 0) mask = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 99) == 0) edge_mode = ~edge_mode;
      irq_ready = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
